// File: rtl/mem_pkg.sv
// Shared encodings for the multi-cycle MEM stage: access sizes, FSM states, I/O offsets.
package mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [31:0] IO_IN_OFF   = 32'h0000_0000;
  localparam logic [31:0] IO_DISP_OFF = 32'h0000_0004;
endpackage

// File: rtl/mem_lane_ctrl.sv
// Byte-lane steering for the MEM stage: store byte enables / lane-replicated write data,
// load lane select with sign or zero extension. Purely combinational.
module mem_lane_ctrl
  import mem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte  = i_rword[{i_addr_lo, 3'b000} +: 8];
    w_half  = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
    o_be    = 4'hF;
    o_wdata = i_wdata;
    o_rdata = i_rword;
    case (i_size)
      SZ_BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mem_stage_mc.sv
// MIPS MEM stage with multi-cycle RAM loads, sized accesses and memory-mapped display registers.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_stage_mc
  import mem_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter int          N_DISP      = 8,
  parameter int          MEM_LATENCY = 2,
  parameter logic [31:0] IO_BASE     = 32'hFFFF_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid_i,
  input  logic                  ex_mem_read_i,
  input  logic                  ex_mem_write_i,
  input  logic [1:0]            ex_size_i,
  input  logic                  ex_unsigned_i,
  input  logic [31:0]           ex_addr_i,
  input  logic [31:0]           ex_wdata_i,
  input  logic [31:0]           io_in_i,
  output logic                  stall_o,
  output logic                  wb_valid_o,
  output logic [31:0]           wb_rdata_o,
  output logic [31:0]           wb_alu_o,
  output logic [32*N_DISP-1:0]  disp_o,
  output logic                  err_o
);
  localparam int          AW        = $clog2(DEPTH);
  localparam int          CW        = $clog2(MEM_LATENCY + 1);
  localparam int          DW        = (N_DISP > 1) ? $clog2(N_DISP) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);
  localparam logic [29:0] IO_WORD   = IO_BASE[31:2];
  localparam logic        SLOW_RAM  = (MEM_LATENCY > 1);

  logic [31:0]   r_mem [DEPTH];
  logic [31:0]   r_disp [N_DISP];
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_ld_addr;
  logic [1:0]    r_ld_size;
  logic          r_ld_uns;
  logic          r_wb_valid, r_err;
  logic [31:0]   r_wb_rdata, r_wb_alu;

  logic          w_busy, w_accept, w_mem_op, w_is_load, w_bad, w_misalign, w_slow, w_wr;
  logic          w_hit_ram, w_hit_in, w_hit_disp, w_uns;
  logic [31:0]   w_addr, w_rword, w_wsh, w_rext, w_rdata;
  logic [1:0]    w_size;
  logic [29:0]   w_io_word;
  logic [DW-1:0] w_didx;
  logic [AW-1:0] w_ridx;
  logic [3:0]    w_be;

  // While BUSY the EX/MEM slot already holds the next instruction, so decode the latched load.
  assign w_busy    = (r_state == BUSY);
  assign stall_o   = w_busy;
  assign w_accept  = ex_valid_i && !w_busy;
  assign w_addr    = w_busy ? r_ld_addr : ex_addr_i;
  assign w_size    = w_busy ? r_ld_size : ex_size_i;
  assign w_uns     = w_busy ? r_ld_uns  : ex_unsigned_i;
  assign w_mem_op  = w_busy || ex_mem_read_i || ex_mem_write_i;
  assign w_is_load = w_busy || (ex_mem_read_i && !ex_mem_write_i);

  assign w_io_word  = w_addr[31:2] - IO_WORD;
  assign w_hit_ram  = (w_addr < RAM_BYTES);
  assign w_hit_in   = (w_io_word == IO_IN_OFF[31:2]);
  assign w_hit_disp = (w_io_word >= IO_DISP_OFF[31:2]) && (w_io_word <= 30'(N_DISP));
  assign w_didx     = DW'(w_io_word - IO_DISP_OFF[31:2]);
  assign w_ridx     = w_addr[AW+1:2];

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misalign = ((w_size == SZ_HALF) && w_addr[0]) || (w_size[1] && (w_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_bad  = w_mem_op && (!(w_hit_ram || w_hit_in || w_hit_disp) || w_misalign);
  assign w_slow = SLOW_RAM && ex_mem_read_i && !ex_mem_write_i && w_hit_ram && !w_bad;
  assign w_wr   = w_accept && ex_mem_write_i && !w_bad;

  always_comb begin
    w_rword = 32'h0;
    if (w_hit_ram)       w_rword = r_mem[w_ridx];
    else if (w_hit_in)   w_rword = io_in_i;
    else if (w_hit_disp) w_rword = r_disp[w_didx];
  end

  mem_lane_ctrl u_lane (
    .i_size     (w_size),
    .i_unsigned (w_uns),
    .i_addr_lo  (w_addr[1:0]),
    .i_wdata    (ex_wdata_i),
    .i_rword    (w_rword),
    .o_be       (w_be),
    .o_wdata    (w_wsh),
    .o_rdata    (w_rext)
  );

  assign w_rdata = (w_is_load && !w_bad) ? w_rext : 32'h0;

  always_ff @(posedge clk) begin
    if (w_wr && w_hit_ram) begin
      for (int k = 0; k < 4; k++)
        if (w_be[k]) r_mem[w_ridx][8*k +: 8] <= w_wsh[8*k +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_DISP; i++) r_disp[i] <= 32'h0;
    end else if (w_wr && w_hit_disp) begin
      for (int k = 0; k < 4; k++)
        if (w_be[k]) r_disp[w_didx][8*k +: 8] <= w_wsh[8*k +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_ld_addr  <= 32'h0;
      r_ld_size  <= 2'b00;
      r_ld_uns   <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_rdata <= 32'h0;
      r_wb_alu   <= 32'h0;
      r_err      <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          if (w_slow) begin
            r_state   <= BUSY;
            r_cnt     <= CW'(MEM_LATENCY - 1);
            r_ld_addr <= ex_addr_i;
            r_ld_size <= ex_size_i;
            r_ld_uns  <= ex_unsigned_i;
          end else begin
            r_wb_valid <= 1'b1;
            r_wb_rdata <= w_rdata;
            r_wb_alu   <= ex_addr_i;
            r_err      <= w_bad;
          end
        end
        BUSY: begin
          if (r_cnt == CW'(1)) begin
            r_state    <= IDLE;
            r_wb_valid <= 1'b1;
            r_wb_rdata <= w_rdata;
            r_wb_alu   <= r_ld_addr;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wb_valid_o = r_wb_valid;
  assign wb_rdata_o = r_wb_rdata;
  assign wb_alu_o   = r_wb_alu;
  assign err_o      = r_err;

  for (genvar g = 0; g < N_DISP; g++) begin : g_disp
    assign disp_o[32*g +: 32] = r_disp[g];
  end
endmodule

// File: tb/tb_mem_stage_mc.sv
// Directed scoreboard bench for mem_stage_mc with MEM_LATENCY=3 (covers MEM_MISALIGN_TRAP_EN builds too).
module tb_mem_stage_mc;
  localparam int          DEPTH  = 1024;
  localparam int          N_DISP = 8;
  localparam int          LAT    = 3;
  localparam logic [31:0] IOB    = 32'hFFFF_0000;

  logic clk = 1'b0;
  logic rst;
  logic ex_valid_i, ex_mem_read_i, ex_mem_write_i, ex_unsigned_i;
  logic [1:0] ex_size_i;
  logic [31:0] ex_addr_i, ex_wdata_i, io_in_i;
  logic stall_o, wb_valid_o, err_o;
  logic [31:0] wb_rdata_o, wb_alu_o;
  logic [32*N_DISP-1:0] disp_o;

  always #5 clk = ~clk;

  mem_stage_mc #(.DEPTH(DEPTH), .N_DISP(N_DISP), .MEM_LATENCY(LAT), .IO_BASE(IOB)) dut (
    .clk(clk), .rst(rst), .ex_valid_i(ex_valid_i), .ex_mem_read_i(ex_mem_read_i),
    .ex_mem_write_i(ex_mem_write_i), .ex_size_i(ex_size_i), .ex_unsigned_i(ex_unsigned_i),
    .ex_addr_i(ex_addr_i), .ex_wdata_i(ex_wdata_i), .io_in_i(io_in_i), .stall_o(stall_o),
    .wb_valid_o(wb_valid_o), .wb_rdata_o(wb_rdata_o), .wb_alu_o(wb_alu_o), .disp_o(disp_o),
    .err_o(err_o)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] alu;
    logic        err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_err = 0;
  logic [32*N_DISP-1:0] exp_disp;
  logic [31:0] held;
  logic saw;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one instruction, push its expected result, then wait for the MEM/WB slot.
  task automatic op(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                    input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                    input logic [31:0] exp_rd, input logic exp_err, input int lat);
    exp_t e;
    int cyc;
    int stalls;
    logic seen;
    @(negedge clk);
    ex_valid_i = 1'b1; ex_mem_read_i = rd; ex_mem_write_i = wr; ex_size_i = sz;
    ex_unsigned_i = uns; ex_addr_i = addr; ex_wdata_i = wd;
    e.rdata = exp_rd; e.alu = addr; e.err = exp_err; e.lat = lat;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    ex_valid_i = 1'b0; ex_mem_read_i = 1'b0; ex_mem_write_i = 1'b0; ex_size_i = 2'b00;
    ex_unsigned_i = ~uns; ex_addr_i = 32'hDEAD_BEEF; ex_wdata_i = 32'h0;
    cyc = 1; stalls = 0; seen = 1'b0;
    while (!seen && cyc <= 20) begin
      if (wb_valid_o) seen = 1'b1;
      else begin
        if (stall_o) stalls++;
        cyc++;
        @(negedge clk);
      end
    end
    chk({tag, "_wb_seen"}, seen, 1'b1);
    if (seen) begin
      e = exp_q.pop_front();
      chk({tag, "_rdata"}, wb_rdata_o, e.rdata);
      chk({tag, "_alu"}, wb_alu_o, e.alu);
      chk({tag, "_err"}, err_o, e.err);
      chk({tag, "_latency"}, cyc, e.lat);
      chk({tag, "_stall_cycles"}, stalls, e.lat - 1);
    end
  endtask

  initial begin
    rst = 1'b1; ex_valid_i = 0; ex_mem_read_i = 0; ex_mem_write_i = 0; ex_size_i = 0;
    ex_unsigned_i = 0; ex_addr_i = 0; ex_wdata_i = 0; io_in_i = 0;
    exp_disp = '0;
    repeat (2) @(negedge clk);
    chk("rst_wb_valid", wb_valid_o, 1'b0);
    chk("rst_rdata", wb_rdata_o, 32'h0);
    chk("rst_alu", wb_alu_o, 32'h0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_stall", stall_o, 1'b0);
    chk("rst_disp", disp_o, exp_disp);
    rst = 1'b0;

    op("sw_10", 0, 1, 2'b10, 0, 32'h10, 32'h8000_00FF, 32'h0, 0, 1);
    op("lw_10", 1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h8000_00FF, 0, LAT);
    op("lb_13", 1, 0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFF_FF80, 0, LAT);
    op("lbu_13", 1, 0, 2'b00, 1, 32'h13, 32'h0, 32'h0000_0080, 0, LAT);
    op("lh_12", 1, 0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFF_8000, 0, LAT);
    op("sb_11", 0, 1, 2'b00, 0, 32'h11, 32'h0000_005A, 32'h0, 0, 1);
    op("lw_10b", 1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h8000_5AFF, 0, LAT);
    held = wb_rdata_o;
    @(negedge clk);
    chk("idle_wb_valid", wb_valid_o, 1'b0);
    chk("idle_rdata_hold", wb_rdata_o, held);

    op("sw_disp2", 0, 1, 2'b10, 0, IOB + 32'd12, 32'h0000_1234, 32'h0, 0, 1);
    exp_disp[95:64] = 32'h0000_1234;
    chk("disp_after_sw", disp_o, exp_disp);
    op("sb_disp2", 0, 1, 2'b00, 0, IOB + 32'd15, 32'h0000_00AB, 32'h0, 0, 1);
    exp_disp[95:64] = 32'hAB00_1234;
    chk("disp_after_sb", disp_o, exp_disp);
    op("lh_disp2", 1, 0, 2'b01, 0, IOB + 32'd14, 32'h0, 32'hFFFF_AB00, 0, 1);
    io_in_i = 32'h0000_CAFE;
    op("lw_io_in", 1, 0, 2'b10, 0, IOB, 32'h0, 32'h0000_CAFE, 0, 1);
    op("alu_op", 0, 0, 2'b10, 0, 32'h0000_0777, 32'h5555_5555, 32'h0, 0, 1);

    op("lw_oor", 1, 0, 2'b10, 0, DEPTH * 4, 32'h0, 32'h0, 1, 1);
    op("sw_oor", 0, 1, 2'b10, 0, DEPTH * 4, 32'h1111_1111, 32'h0, 1, 1);
    op("sw_rw_both", 1, 1, 2'b10, 0, 32'h20, 32'h1111_2222, 32'h0, 0, 1);
    op("lw_sz11", 1, 0, 2'b11, 0, 32'h20, 32'h0, 32'h1111_2222, 0, LAT);

    // Reset in the middle of a BUSY load.
    @(negedge clk);
    ex_valid_i = 1; ex_mem_read_i = 1; ex_mem_write_i = 0; ex_size_i = 2'b10; ex_addr_i = 32'h10;
    @(posedge clk);
    @(negedge clk);
    ex_valid_i = 0; ex_mem_read_i = 0;
    chk("busy_stall", stall_o, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy_stall", stall_o, 1'b0);
    chk("rst_busy_wb_valid", wb_valid_o, 1'b0);
    chk("rst_busy_disp", disp_o, {32*N_DISP{1'b0}});
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (wb_valid_o) saw = 1'b1;
    end
    chk("no_wb_after_rst", saw, 1'b0);
    op("lw_after_rst", 1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h8000_5AFF, 0, LAT);

`ifdef MEM_MISALIGN_TRAP_EN
    op("sw_mis", 0, 1, 2'b10, 0, 32'h12, 32'hFFFF_FFFF, 32'h0, 1, 1);
    op("lw_after_mis", 1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h8000_5AFF, 0, LAT);
    op("lh_mis", 1, 0, 2'b01, 0, 32'h11, 32'h0, 32'h0, 1, 1);
`else
    op("sw_unaligned", 0, 1, 2'b10, 0, 32'h12, 32'hFFFF_FFFF, 32'h0, 0, 1);
    op("lw_after_unal", 1, 0, 2'b10, 0, 32'h10, 32'h0, 32'hFFFF_FFFF, 0, LAT);
    op("lh_unaligned", 1, 0, 2'b01, 0, 32'h11, 32'h0, 32'hFFFF_FFFF, 0, LAT);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
